// File: rtl/fifo_rd_arbiter.sv
`timescale 1ns/1ps
// fifo_rd_arbiter: round-robin burst arbiter sharing the async FIFO read port among NREQ consumers.
// The owner keeps the port for up to BURST pops and loses it early on a dropped request or a long empty stall.
module fifo_rd_arbiter #(
  parameter int DSIZE     = 8,
  parameter int NREQ      = 4,
  parameter int BURST     = 4,
  parameter int STALL_MAX = 8,
  localparam int LW = $clog2(NREQ),
  localparam int BW = $clog2(BURST + 1),
  localparam int SW = $clog2(STALL_MAX + 1)
) (
  input  logic             rclk,
  input  logic             rrst,
  input  logic             rempty,
  input  logic [DSIZE-1:0] rdata,
  output logic             rinc,
  input  logic [NREQ-1:0]  req,
  output logic [NREQ-1:0]  gnt,
  output logic [DSIZE-1:0] out_data,
  output logic [NREQ-1:0]  out_valid,
  output logic             busy,
  output logic             dbg_state,
  output logic [BW-1:0]    dbg_beat,
  output logic [SW-1:0]    dbg_stall,
  output logic [LW-1:0]    dbg_last
);
  typedef enum logic {S_IDLE = 1'b0, S_XFER = 1'b1} state_t;

  state_t           r_state;
  logic [NREQ-1:0]  r_gnt;
  logic [NREQ-1:0]  r_valid;
  logic [DSIZE-1:0] r_data;
  logic             r_busy;
  logic [LW-1:0]    r_owner;
  logic [LW-1:0]    r_last;
  logic [BW-1:0]    r_beat;
  logic [SW-1:0]    r_stall;

  logic [LW-1:0]    w_pick;
  logic [LW-1:0]    w_cand;
  logic             w_found;
  logic             w_owner_req;
  logic             w_pop;
  logic             w_release;
  logic [NREQ-1:0]  w_owner_oh;
  logic [NREQ-1:0]  w_pick_oh;

  // Round-robin scan starting just after the previous owner, wrapping around.
  always_comb begin
    w_pick  = r_last;
    w_found = 1'b0;
    w_cand  = '0;
    for (int k = 1; k <= NREQ; k++) begin
      w_cand = LW'((int'(r_last) + k) % NREQ);
      if (!w_found && req[w_cand]) begin
        w_found = 1'b1;
        w_pick  = w_cand;
      end
    end
  end

  assign w_owner_req = req[r_owner];
  assign w_owner_oh  = NREQ'(1) << r_owner;
  assign w_pick_oh   = NREQ'(1) << w_pick;

  // Handshake: rinc pops the FIFO head in the same cycle (only when rempty==0, so no underflow);
  // out_valid is a one-cycle, one-hot strobe for out_data with no back-pressure from consumers.
  assign w_pop     = (r_state == S_XFER) && !rempty && w_owner_req;
  assign w_release = (r_state == S_XFER) &&
                     ((w_pop && (r_beat == BW'(BURST - 1))) ||
                      !w_owner_req ||
                      (rempty && (r_stall == SW'(STALL_MAX - 1))));

  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      r_state <= S_IDLE;
      r_gnt   <= '0;
      r_valid <= '0;
      r_data  <= '0;
      r_busy  <= 1'b0;
      r_owner <= '0;
      r_last  <= LW'(NREQ - 1);
      r_beat  <= '0;
      r_stall <= '0;
    end else begin
      r_valid <= '0;
      if (r_state == S_IDLE) begin
        if (w_found && !rempty) begin
          r_state <= S_XFER;
          r_owner <= w_pick;
          r_gnt   <= w_pick_oh;
          r_busy  <= 1'b1;
          r_beat  <= '0;
          r_stall <= '0;
        end
      end else begin
        if (w_pop) begin
          r_data  <= rdata;
          r_valid <= w_owner_oh;
          r_beat  <= r_beat + 1'b1;
          r_stall <= '0;
        end else if (w_owner_req) begin
          r_stall <= r_stall + 1'b1;
        end
        // Counters stop at BURST / STALL_MAX on release and restart on the next grant.
        if (w_release) begin
          r_state <= S_IDLE;
          r_gnt   <= '0;
          r_busy  <= 1'b0;
          r_last  <= r_owner;
        end
      end
    end
  end

  assign rinc      = w_pop;
  assign gnt       = r_gnt;
  assign out_data  = r_data;
  assign out_valid = r_valid;
  assign busy      = r_busy;
  assign dbg_state = (r_state == S_XFER);
  assign dbg_beat  = r_beat;
  assign dbg_stall = r_stall;
  assign dbg_last  = r_last;

endmodule
